// File: rtl/pingpong_fmap_bram_pkg.sv
// Shared types and helpers for the ping-pong feature-map buffer.
package pingpong_fmap_bram_pkg;

  typedef logic bank_t;

  localparam int unsigned ADDR_MAX_W = 64;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Callers truncate the result to their word-address width, which wraps modulo DEPTH.
  function automatic logic [ADDR_MAX_W-1:0] word_index(input logic [ADDR_MAX_W-1:0] byte_addr,
                                                      input int unsigned byte_shift);
    return byte_addr >> byte_shift;
  endfunction

endpackage

// File: rtl/pingpong_fmap_bram_bank.sv
// One block-RAM bank: single write port, single registered read port.
module pingpong_fmap_bram_bank
  import pingpong_fmap_bram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 65536,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register resets to zero so the buffer's read data starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pingpong_fmap_bram.sv
// Double-buffered feature-map store: producer fills one bank while the consumer reads the other.
module pingpong_fmap_bram
  import pingpong_fmap_bram_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 65536,
  parameter int unsigned WADDR_W    = 16,
  parameter int unsigned RADDR_W    = 20,
  parameter int unsigned BYTE_SHIFT = 2,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [WADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_last,
  output logic               wr_ready,
  input  logic               rd_en,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               rd_ready,
  input  logic               rd_done,
  output logic               wr_bank,
  output logic               rd_bank,
  output logic               err_ovf
);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("pingpong_fmap_bram: RD_LAT must be 1 or 2");
  end

  logic [1:0]        full;
  logic [1:0]        full_nxt;
  bank_t             wsel;
  bank_t             rsel;
  logic              wr_acc;
  logic              wr_fill;
  logic              rd_acc;
  logic              rd_rel;
  logic [WADDR_W-1:0] rd_widx;

  assign wr_ready = ~full[wsel];
  assign rd_ready = full[rsel];
  assign wr_bank  = wsel;
  assign rd_bank  = rsel;

  assign wr_acc  = wr_en & wr_ready;
  assign wr_fill = wr_acc & wr_last;
  assign rd_acc  = rd_en & rd_ready;
  assign rd_rel  = rd_done & rd_ready;
  assign rd_widx = WADDR_W'(word_index(ADDR_MAX_W'(rd_addr), BYTE_SHIFT));

  // Fill and release always hit different banks, so both updates can apply together.
  always_comb begin
    full_nxt = full;
    if (wr_fill) begin
      full_nxt[wsel] = 1'b1;
    end
    if (rd_rel) begin
      full_nxt[rsel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_fill) begin
        wsel <= ~wsel;
      end
      if (rd_rel) begin
        rsel <= ~rsel;
      end
      if (wr_en && !wr_ready) begin
        err_ovf <= 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] bank_q [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_fmap_bram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (WADDR_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc && (wsel == bank_t'(b))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (rd_acc && (rsel == bank_t'(b))),
      .raddr (rd_widx),
      .rdata (bank_q[b])
    );
  end

  // The bank select is captured with the request, so a read issued alongside rd_done still
  // returns data from the bank it was issued to.
  bank_t             lat_sel;
  logic              valid1;
  logic [DATA_W-1:0] data1;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1  <= 1'b0;
      lat_sel <= 1'b0;
    end else begin
      valid1 <= rd_acc;
      if (rd_acc) begin
        lat_sel <= rsel;
      end
    end
  end

  assign data1 = bank_q[lat_sel];

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] data2;
    logic              valid2;

    always_ff @(posedge clk) begin
      if (rst) begin
        data2  <= '0;
        valid2 <= 1'b0;
      end else begin
        valid2 <= valid1;
        if (valid1) begin
          data2 <= data1;
        end
      end
    end

    assign rd_data  = data2;
    assign rd_valid = valid2;
  end else begin : g_lat1
    assign rd_data  = data1;
    assign rd_valid = valid1;
  end

endmodule
